// File: rtl/sar_adc_ctrl.sv
// Successive-approximation conversion sequencer: start -> sample -> N bit trials -> one-cycle done.
// Optional out-of-range flag on oor is built only when ADC_RANGE_CHECK_EN is defined.
module sar_adc_ctrl #(
   parameter int unsigned N = 3
) (
   input  logic         CLK,
   input  logic         RST,
   input  logic         start,
   input  real          VIN,
   input  real          VSUP,
   output real          vdac,
   output logic         busy,
   output logic         done,
   output logic [N-1:0] code,
   output logic         oor
);
   localparam int unsigned KW        = (N > 1) ? $clog2(N) : 1;
   localparam real         LSB_SCALE = 1.0 / (2.0 ** N);
   localparam logic [N-1:0] FIRST    = N'(1) << (N - 1);

   typedef enum logic [1:0] {IDLE, SAMPLE, CONV, DONE} state_t;

   state_t        state;
   real           vs;
   real           vf;
   real           vcmp;
   logic [N-1:0]  trial;
   logic [N-1:0]  trial_nxt;
   logic [KW-1:0] k;

   // Decision for bit k plus the trial bit for k-1 in one step.
   always_comb begin
      vcmp      = real'(trial) * vf * LSB_SCALE;
      trial_nxt = trial;
      if (!(vs >= vcmp)) trial_nxt[k] = 1'b0;
      if (k != '0) trial_nxt[k - KW'(1)] = 1'b1;
   end

`ifdef ADC_RANGE_CHECK_EN
   logic oor_s;
`else
   assign oor = 1'b0;
`endif

   always_ff @(posedge CLK) begin
      if (RST) begin
         state <= IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
         code  <= '0;
         vdac  <= 0.0;
         vs    <= 0.0;
         vf    <= 0.0;
         trial <= '0;
         k     <= '0;
`ifdef ADC_RANGE_CHECK_EN
         oor_s <= 1'b0;
         oor   <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  state <= SAMPLE;
                  busy  <= 1'b1;
               end
            end
            SAMPLE: begin
               vs    <= VIN;
               vf    <= VSUP;
               trial <= FIRST;
               k     <= KW'(N - 1);
               vdac  <= real'(FIRST) * VSUP * LSB_SCALE;
`ifdef ADC_RANGE_CHECK_EN
               oor_s <= (VIN < 0.0) || (VIN > VSUP);
`endif
               state <= CONV;
            end
            CONV: begin
               trial <= trial_nxt;
               if (k != '0) begin
                  k    <= k - KW'(1);
                  vdac <= real'(trial_nxt) * vf * LSB_SCALE;
               end else begin
                  code  <= trial_nxt;
                  vdac  <= 0.0;
                  busy  <= 1'b0;
                  done  <= 1'b1;
`ifdef ADC_RANGE_CHECK_EN
                  oor   <= oor_s;
`endif
                  state <= DONE;
               end
            end
            DONE: begin
               done  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
